// File: rtl/dmem_access_sequencer_if.sv
// Load/store request, response and data-memory port bundle for dmem_access_sequencer.
// master = core + memory side, slave = the sequencer.
interface dmem_access_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_fn3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_we, req_fn3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_fn3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/dmem_access_sequencer.sv
// Load/store sequencer for a one-cycle-latency single-port data memory:
// sub-word stores as read-merge-write, loads with lane extraction and extension.
module dmem_access_sequencer #(
  parameter int unsigned ADDR_W = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  dmem_access_sequencer_if.slave bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  localparam logic [2:0] FN_B  = 3'b000;
  localparam logic [2:0] FN_H  = 3'b001;
  localparam logic [2:0] FN_W  = 3'b010;
  localparam logic [2:0] FN_BU = 3'b100;
  localparam logic [2:0] FN_HU = 3'b101;

  // Illegal funct3 for the direction, or address not aligned to the access size.
  function automatic logic access_bad(input logic we, input logic [2:0] fn3,
                                      input logic [1:0] off);
    logic illegal;
    logic misaligned;
    if (we) illegal = !(fn3 == FN_B || fn3 == FN_H || fn3 == FN_W);
    else    illegal = !(fn3 == FN_B || fn3 == FN_H || fn3 == FN_W ||
                        fn3 == FN_BU || fn3 == FN_HU);
    misaligned = ((fn3[1:0] == 2'b01) && off[0]) ||
                 ((fn3[1:0] == 2'b10) && (off != 2'b00));
    return illegal || misaligned;
  endfunction

  // Splice the store byte/halfword into the word read from memory.
  function automatic logic [DATA_W-1:0] store_merge(input logic [2:0] fn3,
                                                    input logic [1:0] off,
                                                    input logic [DATA_W-1:0] old,
                                                    input logic [HALF_W-1:0] wd);
    logic [DATA_W-1:0] w;
    w = old;
    if (fn3[1:0] == 2'b00) w[{off, 3'b000} +: 8]      = wd[7:0];
    else                   w[{off[1], 4'b0000} +: 16] = wd;
    return w;
  endfunction

  // Right-align the addressed lane, then sign- or zero-extend it.
  function automatic logic [DATA_W-1:0] load_extract(input logic [2:0] fn3,
                                                     input logic [1:0] off,
                                                     input logic [DATA_W-1:0] rd);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] res;
    sh = rd >> {off, 3'b000};
    case (fn3)
      FN_B:    res = {{24{sh[7]}}, sh[7:0]};
      FN_BU:   res = {24'd0, sh[7:0]};
      FN_H:    res = {{16{sh[15]}}, sh[15:0]};
      FN_HU:   res = {16'd0, sh[15:0]};
      default: res = rd;
    endcase
    return res;
  endfunction

  logic [2:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        fn3_q, fn3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              re_q, re_d;
  logic              wr_q, wr_d;
  logic              rv_q, rv_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  // Next state, latched request fields and next registered outputs.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    fn3_d   = fn3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && ready_q) begin
          we_d    = bus.req_we;
          fn3_d   = bus.req_fn3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (access_bad(bus.req_we, bus.req_fn3, bus.req_addr[1:0])) begin
            state_d = ST_RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (bus.req_we && (bus.req_fn3 == FN_W)) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (we_q) begin
          wdata_d = store_merge(fn3_q, addr_q[1:0], bus.mem_rdata, wdata_q[HALF_W-1:0]);
          state_d = ST_WR;
        end else begin
          rdata_d = load_extract(fn3_q, addr_q[1:0], bus.mem_rdata);
          err_d   = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_WR: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    re_d    = (state_d == ST_RD);
    wr_d    = (state_d == ST_WR);
    rv_d    = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      fn3_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      re_q    <= 1'b0;
      wr_q    <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      fn3_q   <= fn3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      re_q    <= re_d;
      wr_q    <= wr_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // wdata_q carries the store data, replaced by the merged word for sub-word stores.
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_re    = re_q;
  assign bus.mem_we    = wr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_dmem_access_sequencer.sv
// Scoreboard bench for dmem_access_sequencer: byte-level reference model,
// directed corner cases, then randomized load/store traffic.
module tb_dmem_access_sequencer;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned NWORDS = 256;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_access_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
  dmem_access_sequencer #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] dmem    [NWORDS];
  logic [31:0] ref_mem [NWORDS];
  logic        fill = 1'b0;
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  exp_t exp_q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int n_wr = 0;
  int exp_wr = 0;
  int last_rsp_cyc = -10;

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_A5A5;
  endfunction

  // Synchronous memory with one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fill) for (int i = 0; i < NWORDS; i++) dmem[i] <= init_word(i);
    if (poke_en) dmem[poke_idx] <= poke_val;
    if (bus.mem_re) bus.mem_rdata <= dmem[bus.mem_addr[9:2]];
    if (bus.mem_we) dmem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: applies the access to ref_mem byte by byte and predicts the response.
  function automatic exp_t model(input logic we, input logic [2:0] fn3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int nb, off, idx;
    bit legal, mis;
    logic [31:0] w, mask;
    nb  = 1 << fn3[1:0];
    off = int'(addr[1:0]);
    idx = int'(addr[9:2]);
    legal = we ? (fn3 <= 3'd2) : (fn3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = (off % nb) != 0;
    e.rdata = '0; e.err = 1'b0; e.acc = 0; e.lat = 0;
    if (!legal || mis) begin
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
    w = ref_mem[idx];
    if (we) begin
      for (int i = 0; i < nb; i++) w[(off + i) * 8 +: 8] = wdata[i * 8 +: 8];
      ref_mem[idx] = w;
      exp_wr++;
      e.lat = (nb == 4) ? 2 : 4;
    end else begin
      e.rdata = w >> (off * 8);
      if (nb < 4) begin
        mask = (32'd1 << (nb * 8)) - 32'd1;
        e.rdata = e.rdata & mask;
        if (!fn3[2] && e.rdata[nb * 8 - 1]) e.rdata = e.rdata | ~mask;
      end
      e.lat = 3;
    end
    return e;
  endfunction

  // Monitor: strobe exclusivity, write count, and scoreboard on every response.
  always @(negedge clk) begin
    if (bus.mem_we) n_wr++;
    if (rst_n) begin
      if (bus.mem_re || bus.mem_we)
        check("re_we_exclusive", 32'(bus.mem_re & bus.mem_we), 32'd0);
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid with rdata 0x%08h, required no response", bus.rsp_rdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          check("latency", 32'(cyc - e.acc), 32'(e.lat));
        end
        last_rsp_cyc = cyc;
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] val);
    poke_idx = 8'(idx);
    poke_val = val;
    poke_en  = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Present a request (called at a negedge); keep leaves req_valid high afterwards.
  task automatic issue(input logic we, input logic [2:0] fn3, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit keep, input bit b2b,
                       input bit fixed, input logic [31:0] fixed_rdata);
    exp_t e;
    int n;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_fn3   = fn3;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    if (b2b) check("b2b_accept_cycle", 32'(cyc), 32'(last_rsp_cyc + 1));
    e = model(we, fn3, addr, wdata);
    e.acc = cyc;
    if (fixed) e.rdata = fixed_rdata;
    exp_q.push_back(e);
    @(negedge clk);
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("rsp_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int wr0;
    logic [31:0] w200;
    bit prev_keep;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_fn3   = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    fill = 1'b1;
    repeat (3) @(negedge clk);
    fill = 1'b0;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset_mem_re", 32'(bus.mem_re), 32'd0);
    check("reset_mem_we", 32'(bus.mem_we), 32'd0);
    check("reset_mem_addr", bus.mem_addr, 32'd0);
    check("reset_mem_wdata", bus.mem_wdata, 32'd0);

    // Full-word store, then byte store into a known word.
    issue(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, '0);
    wait_idle();
    check("sw_word", dmem[64], 32'hDEAD_BEEF);
    poke(64, 32'h1122_3344);
    issue(1'b1, 3'b000, 32'h102, 32'h0000_00AB, 0, 0, 0, '0);
    wait_idle();
    check("sb_merge", dmem[64], 32'h11AB_3344);

    // Sign/zero-extended loads from a fixed pattern.
    poke(16, 32'h8000_F0FF);
    issue(1'b0, 3'b000, 32'h40, '0, 0, 0, 1, 32'hFFFF_FFFF);
    issue(1'b0, 3'b100, 32'h40, '0, 0, 0, 1, 32'h0000_00FF);
    issue(1'b0, 3'b001, 32'h42, '0, 0, 0, 1, 32'hFFFF_8000);
    issue(1'b0, 3'b101, 32'h42, '0, 0, 0, 1, 32'h0000_8000);
    wait_idle();

    // Misaligned and illegal requests: error response, no memory write.
    wr0 = n_wr;
    issue(1'b1, 3'b001, 32'h101, 32'h1234_5678, 0, 0, 0, '0);
    issue(1'b0, 3'b010, 32'h102, '0, 0, 0, 0, '0);
    issue(1'b1, 3'b011, 32'h100, 32'h1234_5678, 0, 0, 0, '0);
    wait_idle();
    check("err_no_write", 32'(n_wr - wr0), 32'd0);

    // Reset during the WAIT of a byte store abandons it.
    wr0  = n_wr;
    w200 = ref_mem[128];
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_fn3   = 3'b000;
    bus.req_addr  = 32'h201;
    bus.req_wdata = 32'h0000_0077;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_write", 32'(n_wr - wr0), 32'd0);
    check("midrst_word_kept", dmem[128], w200);
    issue(1'b1, 3'b010, 32'h204, 32'hCAFE_F00D, 0, 0, 0, '0);
    wait_idle();

    // Back-to-back with req_valid held.
    wr0 = n_wr;
    issue(1'b1, 3'b010, 32'h300, 32'h0101_0101, 1, 0, 0, '0);
    issue(1'b1, 3'b010, 32'h304, 32'h0202_0202, 0, 1, 0, '0);
    wait_idle();
    check("b2b_writes", 32'(n_wr - wr0), 32'd2);

    // Randomized traffic.
    prev_keep = 0;
    for (int k = 0; k < 300; k++) begin
      bit keep;
      keep = (k != 299) && ($urandom_range(0, 3) == 0);
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
            $urandom, keep, prev_keep, 0, '0);
      prev_keep = keep;
      if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.req_valid = 1'b0;
    wait_idle();

    for (int i = 0; i < NWORDS; i++) check($sformatf("mem_word_%0d", i), dmem[i], ref_mem[i]);
    check("write_count", 32'(n_wr), 32'(exp_wr));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_access_sequencer.md
# dmem_access_sequencer

Multi-cycle data-memory access sequencer between the core's load/store stage and a synchronous single-port data memory with one-cycle read latency. Performs sub-word stores (SB/SH) as read-merge-write at the correct byte lane given by the address offset, and full-word stores (SW) as a direct write. Performs loads with lane extraction and sign or zero extension. Rejects misaligned or illegal accesses without touching memory.

## Interface
- ADDR_W, 32, byte-address width; `mem_addr` is word-aligned.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_fn3  in  3  RISC-V funct3 of the load/store
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data (rs2)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal fn3, qualified by rsp_valid
- mem_addr  out  ADDR_W  {addr[ADDR_W-1:2], 2'b00}
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  valid the cycle after mem_re

## Operation
- States: IDLE, RD, WAIT, WR, RESP. All outputs are decoded from state and registered request fields (Moore); no combinational path from req_* to mem_*.
- IDLE, with req_valid & req_ready:
  - Latch we, fn3, addr, wdata.
  - Error: go to RESP with err=1.
  - Store with fn3=010: go to WR.
  - Any other legal request: go to RD.
- Errors:
  - Illegal fn3: stores other than 000/001/010; loads other than 000/001/010/100/101.
  - Misaligned: halfword access with addr[0]=1; word access with addr[1:0]≠0.
- RD: mem_re=1. Next state is WAIT.
- WAIT: capture mem_rdata.
  - Load: go to RESP with extracted data.
  - Store: go to WR with merged word.
- Store merge:
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces halfword lane addr[1] with wdata[15:0].
  - All other bytes keep their read values.
  - SW writes wdata unchanged.
- Load extraction (lane selected by addr[1:0]):
  - LB/LBU: selected byte, sign- or zero-extended.
  - LH/LHU: halfword lane addr[1], sign- or zero-extended.
  - LW: full word.
- WR: mem_we=1, mem_wdata = merged or full word. Next state is RESP.
- RESP: rsp_valid=1 for exactly one cycle, rsp_rdata and rsp_err driven. Next state is IDLE. No response backpressure.
- mem_addr is held stable from RD through WR.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_re=0, mem_we=0, mem_wdata=0, mem_addr=0, all latched fields 0.
- Latency counts the accept edge as cycle 0; rsp_valid is high in the listed cycle:
  - Error: cycle 1.
  - SW: WR in cycle 1, rsp_valid in cycle 2.
  - Load: RD in cycle 1, WAIT in cycle 2, rsp_valid in cycle 3.
  - SB/SH: RD in cycle 1, WAIT in cycle 2, WR in cycle 3, rsp_valid in cycle 4.
- req_ready is low from the cycle after accept through RESP inclusive. A new request can be accepted in the cycle after rsp_valid.
- req_valid while busy is ignored and not queued. The requester holds the request until it sees req_ready.
- mem_re and mem_we are never high in the same cycle. There is at most one write per request.
- Reset asserted mid-operation forces IDLE immediately and drops mem_we/mem_re asynchronously. A pending read-modify-write is abandoned with no write issued and no response.
- rsp_rdata holds its value until the next RESP or reset. rsp_err is cleared on every RESP that has no error.

## Test plan
- Reset, then SW with addr=0x100, wdata=0xDEADBEEF -> cycle 1: mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; cycle 2: rsp_valid=1, rsp_err=0.
- SB with addr=0x102, wdata=0x000000AB, memory word=0x11223344 -> cycle 1: mem_re=1; cycle 3: mem_we=1, mem_wdata=0x11AB3344; cycle 4: rsp_valid=1.
- Loads from word 0x8000F0FF: LB at offset 0 -> 0xFFFFFFFF; LBU at offset 0 -> 0x000000FF; LH at offset 2 -> 0xFFFF8000; LHU at offset 2 -> 0x00008000. Each response arrives in cycle 3.
- SH at addr=0x101 and LW at addr=0x102 -> rsp_valid=1, rsp_err=1, rsp_rdata=0 in cycle 1; mem_re and mem_we never assert. Store with fn3=011 behaves the same.
- rst_n driven low during WAIT of an SB -> mem_we is never asserted, state returns to IDLE, req_ready=1. A following SW completes normally.
- Back-to-back: req_valid held high for two SW requests -> the second is accepted only in the cycle after the first rsp_valid, and exactly two writes occur.
